// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multicycle signed 32-bit divider. The unit divides the operand magnitudes
//   with a radix-2 restoring loop (one quotient bit per clock), then applies
//   the operand signs in a single correction cycle. The quotient truncates
//   toward zero and the remainder takes the sign of the dividend. A zero
//   divisor skips the loop and reports div0 together with done.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   begin a division (only looked at while idle)
//   a      in  32   dividend, two's complement, captured on the accepting edge
//   b      in  32   divisor, two's complement, captured on the accepting edge
//   busy   out  1   division in progress (RUN or FIX)
//   done   out  1   one-cycle pulse, result or div0 valid
//   div0   out  1   one-cycle pulse with done when the divisor was zero
//   hi     out 32   remainder, held until the next successful division
//   lo     out 32   quotient, held until the next successful division
//
// State   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start
// RUN     | 32 restoring-division steps, one quotient bit per edge
// FIX     | sign correction, hi/lo written
// DONE    | done pulse (with div0 on the zero-divisor path)
// ---------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quot;
    logic [31:0] dvs;
    logic        sign_q;
    logic        sign_r;
    logic        div0_flag;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [33:0] trial;
    logic [32:0] shifted_rem;
    logic [32:0] step_rem;
    logic        step_bit;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude.
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;

    // The partial remainder is always below the divisor, so after the shift
    // it fits in 33 bits and bit 33 of the trial difference is the borrow.
    assign shifted_rem = {rem[31:0], quot[31]};
    assign trial       = {rem, quot[31]} - {2'b00, dvs};
    assign step_bit    = ~trial[33];
    assign step_rem    = step_bit ? trial[32:0] : shifted_rem;

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);
    assign div0 = (state == DONE) && div0_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            rem       <= 33'd0;
            quot      <= 32'd0;
            dvs       <= 32'd0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div0_flag <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            div0_flag <= 1'b1;
                            state     <= DONE;
                        end else begin
                            quot      <= abs_a;
                            dvs       <= abs_b;
                            rem       <= 33'd0;
                            sign_q    <= a[31] ^ b[31];
                            sign_r    <= a[31];
                            cnt       <= 6'd0;
                            div0_flag <= 1'b0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem  <= step_rem;
                    quot <= {quot[30:0], step_bit};
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= sign_q ? (~quot + 32'd1) : quot;
                    hi    <= sign_r ? (~rem[31:0] + 32'd1) : rem[31:0];
                    state <= DONE;
                end
                DONE: begin
                    div0_flag <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference copy of the architectural HI/LO contents.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        exp_d0;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: 64-bit signed arithmetic, which truncates toward
    // zero and gives the remainder the sign of the dividend.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb_v,
                         output logic d0, output logic [31:0] ehi, output logic [31:0] elo);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (tb_v == 32'd0) begin
            d0  = 1'b1;
            ehi = m_hi;
            elo = m_lo;
        end else begin
            sa  = {{32{ta[31]}}, ta};
            sb  = {{32{tb_v[31]}}, tb_v};
            q   = sa / sb;
            r   = sa % sb;
            d0  = 1'b0;
            ehi = r[31:0];
            elo = q[31:0];
        end
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                         output int lat, output int busyc, output logic d0_seen,
                         output logic [31:0] rhi, output logic [31:0] rlo);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = 0;
        busyc = 0;
        while (!done && lat < 60) begin
            if (busy) busyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        d0_seen = div0;
        rhi     = hi;
        rlo     = lo;
        @(posedge clk);
        #1;
        chk("done_drop", {31'd0, done}, 32'd0);
    endtask

    task automatic check_div(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic exp_d0, input logic [31:0] ehi, input logic [31:0] elo);
        int          lat;
        int          busyc;
        logic        d0s;
        logic [31:0] rhi;
        logic [31:0] rlo;
        issue(ta, tb_v, lat, busyc, d0s, rhi, rlo);
        chk({name, "_latency"}, lat, exp_d0 ? 32'd0 : 32'd33);
        chk({name, "_busy_cycles"}, busyc, exp_d0 ? 32'd0 : 32'd33);
        chk({name, "_div0"}, {31'd0, d0s}, {31'd0, exp_d0});
        chk({name, "_hi"}, rhi, ehi);
        chk({name, "_lo"}, rlo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        logic        d0;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] ra;
        logic [31:0] rb;
        int          npulse;
        logic [31:0] cap_hi;
        logic [31:0] cap_lo;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd2,          32'd14};
        vecs[1] = '{32'hFFFFFF9C,   32'd7,          1'b0, 32'hFFFFFFFE,   32'hFFFFFFF2};
        vecs[2] = '{32'd100,        32'hFFFFFFF9,   1'b0, 32'd2,          32'hFFFFFFF2};
        vecs[3] = '{32'd100,        32'd7,          1'b0, 32'd2,          32'd14};
        vecs[4] = '{32'd5,          32'd0,          1'b1, 32'd2,          32'd14};
        vecs[5] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000};

        reset = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_div0", {31'd0, div0}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            check_div($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                      vecs[i].exp_d0, vecs[i].exp_hi, vecs[i].exp_lo);
        end
        check_div("zero_dividend", 32'd0, 32'd9, 1'b0, 32'd0, 32'd0);

        // start pulsed mid-run must be ignored
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start  = 1'b0;
        npulse = 0;
        cap_hi = 32'hDEADBEEF;
        cap_lo = 32'hDEADBEEF;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                npulse++;
                cap_hi = hi;
                cap_lo = lo;
            end
            @(posedge clk);
            #1;
        end
        chk("ignore_pulses", npulse, 32'd1);
        chk("ignore_hi", cap_hi, 32'd2);
        chk("ignore_lo", cap_lo, 32'd14);
        m_hi = 32'd2;
        m_lo = 32'd14;
        check_div("after_ignore", 32'd50, 32'd5, 1'b0, 32'd0, 32'd10);

        // asynchronous abort mid-division
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        npulse = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) npulse++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) npulse++;
        end
        chk("abort_no_activity", npulse, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_div("post_reset", 32'd9, 32'd3, 1'b0, 32'd0, 32'd3);

        // randomized operands against the model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'd0 - $urandom_range(1, 20);
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (i % 7 == 0) ra = 32'h80000000;
            model(ra, rb, d0, ehi, elo);
            check_div($sformatf("rand%0d", i), ra, rb, d0, ehi, elo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed 32-bit divider for the multicycle processor datapath. The control unit issues a one-cycle `start` when it decodes a DIV instruction. It then holds its FSM until `done`, and afterwards writes `hi` (remainder) and `lo` (quotient) into the HI/LO registers. Division uses a radix-2 restoring algorithm on operand magnitudes, followed by a sign-correction step. Division by zero is flagged so the control unit can raise its exception path.

## Interface
Parameters:
- none; the width is fixed at 32 bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `start`  in  1  begin a division; sampled only in IDLE.
- `a`  in  32  dividend, two's complement; sampled on the accepting edge.
- `b`  in  32  divisor, two's complement; sampled on the accepting edge.
- `busy`  out  1  high in RUN and FIX.
- `done`  out  1  one-cycle pulse; result or div0 is valid.
- `div0`  out  1  one-cycle pulse coincident with `done` when `b` == 0.
- `hi`  out  32  remainder; held until the next successful division.
- `lo`  out  32  quotient; held until the next successful division.

## Operation
- States: IDLE, RUN, FIX, DONE (2-bit encoding). Internal 6-bit step counter.
- Reset (`reset` low, asynchronous): state = IDLE, counter = 0. All outputs and internal registers are 0.
- IDLE with `start` = 1:
  - `b` == 0: go to DONE with `div0` set. `hi`/`lo` are unchanged.
  - otherwise: latch |a| into the quotient shift register and |b| into the divisor register. Clear the 33-bit partial remainder. Record sign_q = a[31]^b[31] and sign_r = a[31]. Counter = 0. Go to RUN.
- IDLE with `start` = 0: stay in IDLE.
- RUN, one step per edge:
  - Shift {rem, quot} left by one.
  - Trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set quot[0] = 1; else restore and set quot[0] = 0.
  - Counter increments. The step that takes the counter to 32 transitions to FIX.
- FIX, one edge:
  - `lo` = sign_q ? −quot : quot.
  - `hi` = sign_r ? −rem[31:0] : rem[31:0].
  - Go to DONE.
- DONE: `done` = 1 for exactly this cycle. `div0` = 1 only on the zero-divisor path. Next edge goes to IDLE.
- Arithmetic semantics:
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000.
  - 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0. No overflow flag.
- `start` outside IDLE is ignored; no queuing. `a` and `b` are don't-care after the accepting edge.
- `hi`/`lo` change only on the FIX edge or on reset.

## Timing
- Normal latency:
  - Accepting edge E0.
  - RUN occupies edges E1..E32.
  - FIX occurs on E33; `hi`/`lo` update here.
  - `done` is high from E33 to E34.
  - The earliest next accepted `start` is sampled at E35 (issued during the cycle after the `done` pulse, i.e. E34–E35). The unit is in IDLE from E34 but samples `start` on E35.
- Divide-by-zero latency: accepting edge E0, `done` and `div0` high from E0 to E1, IDLE from E1.
- `busy` is high from E0 to E33 on the normal path and never high on the div0 path.
- Reset asserted mid-operation aborts immediately: state = IDLE, `busy`/`done`/`div0` = 0, `hi`/`lo` = 0. Operation resumes on the first edge after `reset` deasserts.

## Test plan
- a = 100, b = 7 -> `done` exactly 33 cycles after the accepting edge; `lo` = 14, `hi` = 2; `busy` high for 33 cycles.
- a = −100 (0xFFFFFF9C), b = 7 -> `lo` = 0xFFFFFFF2 (−14), `hi` = 0xFFFFFFFE (−2). Also a = 100, b = −7 -> `lo` = −14, `hi` = 2.
- After a = 100, b = 7, issue a = 5, b = 0 -> `done` and `div0` high one cycle after start; `busy` never rises; `hi` = 2 and `lo` = 14 are retained.
- a = 0x80000000, b = 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0. Also a = 0, b = 9 -> `lo` = 0, `hi` = 0.
- Pulse `start` with a = 50, b = 5 at cycle 10 of a running 100/7 -> ignored; result is 14 r 2; a single `done` pulse; a new start after DONE yields 10 r 0.
- Assert `reset` low at cycle 15 of a division -> outputs 0 asynchronously (before the next edge); no `done` pulse; after release, 9/3 gives 3 r 0 in 33 cycles.
